// File: rtl/mem_stage_if.sv
// Bundles the upstream instruction, data-memory and writeback signals of mem_stage.
// Pure wiring, so it adds no latency.
// Backpressure is carried by in_ready and mem_ack.
interface mem_stage_if;
    // upstream instruction
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] rs2;
    logic [4:0]  rd;
    // data memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    // writeback
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  exc_code;

    // environment side: drives instructions and memory responses
    modport master (
        output in_valid, opcode, funct3, alu_out, rs2, rd, mem_rdata, mem_ack,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  wb_valid, wb_we, wb_rd, wb_data, exc_code
    );

    // stage side
    modport slave (
        input  in_valid, opcode, funct3, alu_out, rs2, rd, mem_rdata, mem_ack,
        output in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output wb_valid, wb_we, wb_rd, wb_data, exc_code
    );
endinterface

// File: rtl/mem_stage.sv
// Load/store and writeback staging unit behind the ALU; one instruction in flight.
// Latency: non-memory/exception ops write back 1 cycle after accept; memory ops take 2 + wait cycles.
// Backpressure: in_ready only in IDLE; a REQ waits on mem_ack until TIMEOUT_CYCLES then raises a bus timeout.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_stage_if.slave   bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] rs2_q;
    logic [31:0] res_q;
    logic [4:0]  rd_q;
    logic [1:0]  exc_q;
    logic [7:0]  cnt_q;

    logic        in_ld, in_st, in_illegal, in_misal, accept, timeout;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode the incoming instruction: illegal width wins over misalignment.
    always_comb begin
        in_ld      = (bus.opcode == OP_LOAD);
        in_st      = (bus.opcode == OP_STORE);
        in_illegal = 1'b0;
        in_misal   = 1'b0;
        if (in_ld)
            in_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
        else if (in_st)
            in_illegal = (bus.funct3 >= 3'b011);
        if (in_ld || in_st) begin
            if (bus.funct3[1:0] == 2'b01)
                in_misal = bus.alu_out[0];
            else if (bus.funct3[1:0] == 2'b10)
                in_misal = (bus.alu_out[1:0] != 2'b00);
        end
        accept  = (state == IDLE) && bus.in_valid;
        timeout = (state == REQ) && !bus.mem_ack && (cnt_q == TO_LAST);
    end

    // Next-state selection for the IDLE -> (REQ) -> RESP -> IDLE sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)
                      state_nxt = ((in_ld || in_st) && !in_illegal && !in_misal) ? REQ : RESP;
            REQ:  if (bus.mem_ack || timeout)
                      state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any request in flight immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Store lane steering and load extraction from the held address.
    always_comb begin
        case (f3_q[1:0])
            2'b00:   begin st_strb = 4'b0001 << addr_q[1:0]; st_data = {4{rs2_q[7:0]}};  end
            2'b01:   begin st_strb = addr_q[1] ? 4'b1100 : 4'b0011; st_data = {2{rs2_q[15:0]}}; end
            default: begin st_strb = 4'b1111; st_data = rs2_q; end
        endcase
        case (addr_q[1:0])
            2'b00:   ld_byte = bus.mem_rdata[7:0];
            2'b01:   ld_byte = bus.mem_rdata[15:8];
            2'b10:   ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // Capture on accept, collect load data on ack, run the timeout counter in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            f3_q   <= '0;
            addr_q <= '0;
            rs2_q  <= '0;
            res_q  <= '0;
            rd_q   <= '0;
            exc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q   <= bus.opcode;
                    f3_q   <= bus.funct3;
                    addr_q <= bus.alu_out;
                    rs2_q  <= bus.rs2;
                    rd_q   <= bus.rd;
                    exc_q  <= in_illegal ? 2'b11 : (in_misal ? 2'b01 : 2'b00);
                    res_q  <= (in_ld || in_st) ? 32'd0 : bus.alu_out;
                    cnt_q  <= '0;
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        cnt_q <= '0;
                        if (op_q == OP_LOAD) res_q <= ld_data;
                    end else if (timeout) begin
                        cnt_q <= '0;
                        exc_q <= 2'b10;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Outputs are qualified by state so every output is quiet outside its phase.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.mem_req   = (state == REQ);
        bus.mem_we    = (state == REQ) && (op_q == OP_STORE);
        bus.mem_addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : 32'd0;
        bus.mem_wstrb = bus.mem_we ? st_strb : 4'b0000;
        bus.mem_wdata = bus.mem_we ? st_data : 32'd0;
        bus.wb_valid  = (state == RESP);
        bus.wb_we     = (state == RESP) && (exc_q == 2'b00) && (op_q != OP_STORE) && (rd_q != 5'd0);
        bus.wb_rd     = (state == RESP) ? rd_q : 5'd0;
        bus.wb_data   = ((state == RESP) && (exc_q == 2'b00)) ? res_q : 32'd0;
        bus.exc_code  = (state == RESP) ? exc_q : 2'b00;
    end
endmodule
